// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies lock and releases channel resets in a staggered order.
// Latency: pll_lock passes a 2-flop synchroniser; a lock loss reaches every output 3 clkin edges after pll_lock drops.
// Optional lock-loss counter enabled by defining LOCK_LOSS_CNT_EN; no backpressure, runs free on clkin.
module pll_lock_supervisor #(
   parameter int RST_PULSE_CYC    = 16,
   parameter int LOCK_TIMEOUT_CYC = 65536,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int NUM_CH           = 4,
   parameter int CH_STAGGER_CYC   = 8,
   parameter int CNT_W            = 8
) (
   input  logic              clkin,
   input  logic              reset,
   input  logic              pll_lock,
   input  logic              clr_err,
   output logic              pll_reset,
   output logic [NUM_CH-1:0] ch_reset,
   output logic              ready,
   output logic              timeout_err
`ifdef LOCK_LOSS_CNT_EN
   ,
   output logic [CNT_W-1:0]  loss_cnt
`endif
);

   // Each counter only has to reach its terminal value, never wrap.
   localparam int RST_W   = (RST_PULSE_CYC > 1) ? $clog2(RST_PULSE_CYC) : 1;
   localparam int TMO_W   = (LOCK_TIMEOUT_CYC > 1) ? $clog2(LOCK_TIMEOUT_CYC) : 1;
   localparam int STB_W   = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
   localparam int REL_END = (NUM_CH - 1) * CH_STAGGER_CYC + 1;
   localparam int REL_W   = $clog2(REL_END + 1);

   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_PULSE_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYC - 1);
   localparam logic [REL_W-1:0] REL_LAST = REL_W'(REL_END);

   typedef enum logic [2:0] {
      RST_PLL,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN
   } state_t;

   state_t           state;
   logic             sync1;
   logic             lock_s;
   logic [RST_W-1:0] rst_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [STB_W-1:0] stb_cnt;
   logic [REL_W-1:0] rel_cnt;

   // Two-flop synchroniser for the asynchronous lock indication.
   always_ff @(posedge clkin) begin
      if (reset) begin
         sync1  <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         sync1  <= pll_lock;
         lock_s <= sync1;
      end
   end

   // Sequencing FSM with all outputs registered; timeout beats qualification, lock loss beats release.
   always_ff @(posedge clkin) begin
      if (reset) begin
         state       <= RST_PLL;
         rst_cnt     <= '0;
         tmo_cnt     <= '0;
         stb_cnt     <= '0;
         rel_cnt     <= '0;
         pll_reset   <= 1'b1;
         ch_reset    <= '1;
         ready       <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         // A timeout later in this block overrides the clear.
         if (clr_err) timeout_err <= 1'b0;
         case (state)
            RST_PLL: begin
               if (rst_cnt == RST_LAST) begin
                  state     <= WAIT_LOCK;
                  pll_reset <= 1'b0;
                  rst_cnt   <= '0;
                  tmo_cnt   <= '0;
               end else begin
                  rst_cnt <= rst_cnt + RST_W'(1);
               end
            end
            WAIT_LOCK, STABLE: begin
               if (tmo_cnt == TMO_LAST) begin
                  state       <= RST_PLL;
                  rst_cnt     <= '0;
                  pll_reset   <= 1'b1;
                  timeout_err <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
                  if (state == WAIT_LOCK) begin
                     if (lock_s) begin
                        state   <= STABLE;
                        stb_cnt <= '0;
                     end
                  end else if (!lock_s) begin
                     // Lock bounced: look again, the timeout keeps running.
                     state <= WAIT_LOCK;
                  end else if (stb_cnt == STB_LAST) begin
                     state   <= RELEASE;
                     rel_cnt <= '0;
                  end else begin
                     stb_cnt <= stb_cnt + STB_W'(1);
                  end
               end
            end
            RELEASE: begin
               if (!lock_s) begin
                  state     <= RST_PLL;
                  rst_cnt   <= '0;
                  pll_reset <= 1'b1;
                  ch_reset  <= '1;
                  ready     <= 1'b0;
               end else begin
                  for (int k = 0; k < NUM_CH; k++) begin
                     if (rel_cnt == REL_W'(k * CH_STAGGER_CYC)) ch_reset[k] <= 1'b0;
                  end
                  if (rel_cnt == REL_LAST) begin
                     state <= RUN;
                     ready <= 1'b1;
                  end else begin
                     rel_cnt <= rel_cnt + REL_W'(1);
                  end
               end
            end
            RUN: begin
               if (!lock_s) begin
                  state     <= RST_PLL;
                  rst_cnt   <= '0;
                  pll_reset <= 1'b1;
                  ch_reset  <= '1;
                  ready     <= 1'b0;
               end
            end
            default: begin
               state     <= RST_PLL;
               rst_cnt   <= '0;
               pll_reset <= 1'b1;
               ch_reset  <= '1;
               ready     <= 1'b0;
            end
         endcase
      end
   end

`ifdef LOCK_LOSS_CNT_EN
   logic lock_loss;
   assign lock_loss = ((state == RELEASE) || (state == RUN)) && !lock_s;

   // Saturating count of lock losses seen after qualification.
   always_ff @(posedge clkin) begin
      if (reset) begin
         loss_cnt <= '0;
      end else if (lock_loss && (loss_cnt != {CNT_W{1'b1}})) begin
         loss_cnt <= loss_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
// Inputs are driven and outputs sampled 1 time unit after each rising clkin edge.
// Define LOCK_LOSS_CNT_EN to also check the lock-loss counter.
module tb_pll_lock_supervisor;

   logic       clkin;
   logic       reset;
   logic       pll_lock;
   logic       clr_err;
   logic       pll_reset;
   logic [2:0] ch_reset;
   logic       ready;
   logic       timeout_err;
`ifdef LOCK_LOSS_CNT_EN
   logic [1:0] loss_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   pll_lock_supervisor #(
      .RST_PULSE_CYC    (4),
      .LOCK_TIMEOUT_CYC (32),
      .LOCK_STABLE_CYC  (8),
      .NUM_CH           (3),
      .CH_STAGGER_CYC   (2),
      .CNT_W            (2)
   ) dut (
      .clkin       (clkin),
      .reset       (reset),
      .pll_lock    (pll_lock),
      .clr_err     (clr_err),
      .pll_reset   (pll_reset),
      .ch_reset    (ch_reset),
      .ready       (ready),
      .timeout_err (timeout_err)
`ifdef LOCK_LOSS_CNT_EN
      ,
      .loss_cnt    (loss_cnt)
`endif
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clkin);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic pr, input logic [2:0] ch, input logic rdy);
      chk({tag, ".pll_reset"}, {31'd0, pll_reset}, {31'd0, pr});
      chk({tag, ".ch_reset"}, {29'd0, ch_reset}, {29'd0, ch});
      chk({tag, ".ready"}, {31'd0, ready}, {31'd0, rdy});
   endtask

   task automatic chk_loss(input string tag, input int exp);
`ifdef LOCK_LOSS_CNT_EN
      chk({tag, ".loss_cnt"}, {30'd0, loss_cnt}, exp);
`else
      if (exp < 0) $display("unreachable %s", tag);
`endif
   endtask

   logic [2:0] ch_all;

   initial begin
      reset    = 1'b1;
      pll_lock = 1'b1;
      clr_err  = 1'b0;

      // Reset state; Er is the last edge with reset high.
      cyc(2);
      chk_out("rst", 1'b1, 3'b111, 1'b0);
      chk("rst.timeout_err", {31'd0, timeout_err}, 0);
      chk_loss("rst", 0);
      reset = 1'b0;

      // Lock constant high: 4-cycle PLL reset pulse, then staggered release.
      cyc(1);  chk("pulse1", {31'd0, pll_reset}, 1);
      cyc(2);  chk("pulse3", {31'd0, pll_reset}, 1);
      cyc(1);  chk_out("wait_entry", 1'b0, 3'b111, 1'b0);   // Er+4
      cyc(9);  chk_out("rel_entry", 1'b0, 3'b111, 1'b0);    // Er+13
      cyc(1);  chk_out("ch0_fall", 1'b0, 3'b110, 1'b0);     // Er+14
      cyc(1);  chk_out("ch0_hold", 1'b0, 3'b110, 1'b0);
      cyc(1);  chk_out("ch1_fall", 1'b0, 3'b100, 1'b0);     // Er+16
      cyc(2);  chk_out("ch2_fall", 1'b0, 3'b000, 1'b0);     // Er+18
      cyc(1);  chk_out("run", 1'b0, 3'b000, 1'b1);          // Er+19 = N0

      // One-cycle lock drop in RUN: all outputs react together 3 edges later.
      pll_lock = 1'b0;
      cyc(1);  pll_lock = 1'b1;
      chk("drop1.ready", {31'd0, ready}, 1);
      cyc(1);  chk_out("drop2", 1'b0, 3'b000, 1'b1);
      cyc(1);  chk_out("drop3", 1'b1, 3'b111, 1'b0);        // N0+3
      chk_loss("drop3", 1);
      cyc(3);  chk("repulse_hi", {31'd0, pll_reset}, 1);    // N0+6
      cyc(1);  chk("repulse_lo", {31'd0, pll_reset}, 0);    // N0+7
      cyc(14); chk_out("rerun_pre", 1'b0, 3'b000, 1'b0);    // N0+21
      cyc(1);  chk_out("rerun", 1'b0, 3'b000, 1'b1);        // N0+22 = R2

      // Lock lost for good: timeout 32 cycles into WAIT_LOCK.
      pll_lock = 1'b0;
      cyc(3);  chk_out("loss2", 1'b1, 3'b111, 1'b0);        // R2+3
      chk_loss("loss2", 2);
      cyc(35);
      chk("tmo_pre.err", {31'd0, timeout_err}, 0);          // R2+38
      chk("tmo_pre.pr", {31'd0, pll_reset}, 0);
      cyc(1);
      chk("tmo.err", {31'd0, timeout_err}, 1);              // R2+39
      chk("tmo.pr", {31'd0, pll_reset}, 1);
      cyc(3);  chk("tmo_pulse_hi", {31'd0, pll_reset}, 1);  // R2+42
      cyc(1);  chk("tmo_pulse_lo", {31'd0, pll_reset}, 0);  // R2+43
      chk("tmo_sticky", {31'd0, timeout_err}, 1);
      clr_err = 1'b1;
      cyc(1);  chk("clr", {31'd0, timeout_err}, 0);         // R2+44
      clr_err = 1'b0;

      // Clear held across the next timeout edge: set wins, then clear applies.
      cyc(30); chk("tmo2_pre", {31'd0, timeout_err}, 0);    // R2+74
      clr_err = 1'b1;
      cyc(1);  chk("set_wins", {31'd0, timeout_err}, 1);    // R2+75
      cyc(1);  chk("clr_after", {31'd0, timeout_err}, 0);   // R2+76
      clr_err = 1'b0;

      // Lock toggling every 5 cycles never qualifies; timeout at R2+111.
      ch_all = 3'b111;
      for (int i = 0; i < 35; i++) begin
         pll_lock = ((i / 5) % 2) == 0;
         cyc(1);
         ch_all = ch_all & ch_reset;
         if (i == 33) chk("toggle.tmo_pre", {31'd0, timeout_err}, 0);
         if (i == 34) chk("toggle.tmo", {31'd0, timeout_err}, 1);
      end
      chk("toggle.no_release", {29'd0, ch_all}, 32'h7);

      // Lock now steady: requalify, then reset one cycle after ch_reset[0] falls.
      cyc(13); chk_out("rq_rel", 1'b0, 3'b111, 1'b0);      // T+13
      cyc(1);  chk_out("rq_ch0", 1'b0, 3'b110, 1'b0);      // T+14
      reset = 1'b1;
      cyc(1);  chk_out("mid_rst", 1'b1, 3'b111, 1'b0);     // T+15
      chk("mid_rst.err", {31'd0, timeout_err}, 0);
      chk_loss("mid_rst", 0);
      reset = 1'b0;
      cyc(3);  chk("rs_pulse_hi", {31'd0, pll_reset}, 1);  // T+18
      cyc(1);  chk("rs_pulse_lo", {31'd0, pll_reset}, 0);  // T+19
      cyc(14); chk_out("rs_pre_run", 1'b0, 3'b000, 1'b0);  // T+33
      cyc(1);  chk_out("rs_run", 1'b0, 3'b000, 1'b1);      // T+34

      // Five lock losses from RUN; the 2-bit counter saturates at 3.
      for (int k = 0; k < 5; k++) begin
         pll_lock = 1'b0;
         cyc(1);
         pll_lock = 1'b1;
         cyc(2);
         chk_out("sat_loss", 1'b1, 3'b111, 1'b0);
         chk_loss("sat", (k + 1 > 3) ? 3 : k + 1);
         cyc(19);
         chk("sat_rerun", {31'd0, ready}, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter RST_PULSE_CYC, default 16: clkin cycles pll_reset is held high per reset attempt (>=1).
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYC, default 65536: maximum cycles allowed from PLL reset release to qualified lock (>=LOCK_STABLE_CYC+1).
REQ-003 SHALL have parameter LOCK_STABLE_CYC, default 1024: consecutive synchronised lock-high cycles required to qualify lock (>=1).
REQ-004 SHALL have parameter NUM_CH, default 4: number of downstream channel resets (1..16).
REQ-005 SHALL have parameter CH_STAGGER_CYC, default 8: cycles between successive channel reset releases (>=1).
REQ-006 SHALL have parameter CNT_W, default 8: width of the lock-loss counter.
REQ-007 SHALL have port clkin, input, 1: the only clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port pll_lock, input, 1: raw PLL lock, asynchronous to clkin.
REQ-010 SHALL have port clr_err, input, 1: clears timeout_err.
REQ-011 SHALL have port pll_reset, output, 1: drives the PLL RESET pin, active-high.
REQ-012 SHALL have port ch_reset, output, NUM_CH: per-channel active-high synchronous resets.
REQ-013 SHALL have port ready, output, 1: high only when all channels are released and lock is held.
REQ-014 SHALL have port timeout_err, output, 1: sticky lock-timeout flag.
REQ-015 SHALL have port loss_cnt, output, CNT_W: lock-loss count (present only per REQ-033).

Function
REQ-016 SHALL synchronise pll_lock through two flops (lock_s); all decisions use lock_s only, giving 2-cycle input latency.
REQ-017 SHALL implement states RST_PLL, WAIT_LOCK, STABLE, RELEASE, RUN; all outputs registered.
REQ-018 RST_PLL: pll_reset=1, all ch_reset=1, ready=0; after exactly RST_PULSE_CYC cycles in state, go to WAIT_LOCK and clear the timeout timer.
REQ-019 WAIT_LOCK: pll_reset=0; lock_s=1 -> STABLE with stable counter cleared; timeout timer increments every cycle in WAIT_LOCK and STABLE.
REQ-020 STABLE: lock_s=0 -> WAIT_LOCK without clearing the timeout timer; LOCK_STABLE_CYC consecutive lock_s=1 cycles -> RELEASE.
REQ-021 Timeout timer reaching LOCK_TIMEOUT_CYC in WAIT_LOCK or STABLE -> RST_PLL and set timeout_err; timeout has priority over qualification in the same cycle.
REQ-022 RELEASE: ch_reset[0] falls on the first cycle after entry; ch_reset[k] falls exactly k*CH_STAGGER_CYC cycles after ch_reset[0]; once fallen, a bit stays low until lock loss or reset.
REQ-023 After ch_reset[NUM_CH-1] falls, go to RUN; ready rises in the cycle after ch_reset[NUM_CH-1] falls.
REQ-024 RUN: ready=1, pll_reset=0, ch_reset=0; lock_s=0 -> RST_PLL.
REQ-025 Lock loss in RELEASE or RUN: next cycle ready=0, all ch_reset=1, pll_reset=1 (same cycle for all outputs).
REQ-026 timeout_err stays set until clr_err=1; simultaneous set and clr_err -> set wins.
REQ-027 Retries are unlimited; timeout_err does not stop the sequence.
REQ-028 Counter widths SHALL be sized by $clog2 of their terminal value; no counter wraps.

Reset
REQ-029 reset=1 at a clkin edge SHALL force state RST_PLL with its cycle counter cleared, regardless of current state.
REQ-030 Reset values: pll_reset=1, ch_reset all 1, ready=0, timeout_err=0, loss_cnt=0, synchroniser flops 0, all timers 0.
REQ-031 After reset deasserts, pll_reset SHALL remain high for exactly RST_PULSE_CYC further cycles.
REQ-032 Reset asserted mid-RELEASE SHALL re-assert already-released channels on the next edge.

Configuration
REQ-033 Macro LOCK_LOSS_CNT_EN defined: loss_cnt port exists, increments by 1 on each lock loss detected in RELEASE or RUN, saturates at 2^CNT_W-1, cleared only by reset.
REQ-034 Macro LOCK_LOSS_CNT_EN undefined: loss_cnt port and counter logic are absent; all other behaviour is identical.

Verification (RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, NUM_CH=3, CH_STAGGER_CYC=2)
REQ-035 Reset release, pll_lock=1 constant -> pll_reset high for 4 cycles; ch_reset bits fall in order at 2-cycle spacing; ready=1 the cycle after ch_reset[2] falls.
REQ-036 pll_lock held 0 -> timeout_err=1 after 32 cycles in WAIT_LOCK, pll_reset re-pulses for 4 cycles; clr_err pulse clears timeout_err.
REQ-037 pll_lock toggling every 5 cycles -> STABLE never qualifies, timeout at cycle 32, no ch_reset bit ever falls.
REQ-038 In RUN, pll_lock drops for 1 cycle -> ready=0, ch_reset=3'b111, pll_reset=1 together 3 cycles later; loss_cnt=1 (macro on).
REQ-039 With LOCK_LOSS_CNT_EN, CNT_W=2, 5 lock losses -> loss_cnt saturates at 3.
REQ-040 reset asserted one cycle after ch_reset[0] falls -> ch_reset=3'b111 next edge; full sequence restarts with 4-cycle pll_reset pulse.
